datapath_sequencer: RTL

- Upstream control stage for the Datapath (4-entry register file + ALU). Buffers micro-instructions in a small FIFO and, on a start command, issues one per clock on the Datapath's addr1/addr2/addr3/ALUControl/wr inputs.
- Replaces hand-driven stimulus with a valid/ready loader plus a start/busy/done run handshake.
- All Datapath-facing outputs are registered.

---
 rtl/datapath_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// Micro-instruction sequencer feeding the Datapath: a small FIFO loaded via valid/ready,
// drained one entry per clock onto the Datapath control inputs after a start command.
module datapath_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [9:0]       in_instr,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_count,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  output logic [2:0]       ALUControl,
  output logic             wr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [9:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [9:0]       head;
  logic             push, pop;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = (state == RUN) && (count != '0);
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // FIFO storage holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // FIFO control: pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (count == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Issue stage: fields hold their last values outside RUN, wr is forced low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr1        <= '0;
      addr2        <= '0;
      addr3        <= '0;
      ALUControl   <= '0;
      wr           <= 1'b0;
      issued_count <= '0;
    end else begin
      if (state == IDLE && start) issued_count <= '0;
      if (pop) begin
        ALUControl <= head[9:7];
        addr1      <= head[6:5];
        addr2      <= head[4:3];
        addr3      <= head[2:1];
        wr         <= head[0];
        if (issued_count != CNT_MAX) issued_count <= issued_count + 1'b1;
      end else begin
        wr <= 1'b0;
      end
    end
  end

endmodule
